// File: rtl/add_pkg.sv
// Shared types and constants for the pipelined adder/subtractor.
// pipe_beat_t is sized for the widest supported configuration; narrower builds use the low bits.
package add_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   localparam int unsigned DEF_WIDTH  = 32;
   localparam int unsigned DEF_STAGES = 4;
   localparam int unsigned PIPE_MAX_W = 64;

   typedef struct packed {
      logic                  valid;
      logic                  sub;
      logic                  carry;
      logic [PIPE_MAX_W-1:0] a_rem;
      logic [PIPE_MAX_W-1:0] b_rem;
      logic [PIPE_MAX_W-1:0] s_done;
   } pipe_beat_t;

endpackage

// File: rtl/add_pipe_stage.sv
// One CHUNK-bit slice of the pipelined adder together with its stage register.
// Consumes the low CHUNK bits of the remaining operands and shifts the slice sum into s_done.
module add_pipe_stage
   import add_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned CHUNK = DEF_WIDTH / DEF_STAGES
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_adv,
   input  pipe_beat_t i_beat,
   output pipe_beat_t o_beat
);

   logic [CHUNK:0] w_sum;
   pipe_beat_t     w_next;
   pipe_beat_t     r_beat;

   // Operands shift arithmetically so the last stage still sees their sign bits in bit 0;
   // the slice sum enters at the top of the WIDTH window and settles in place after STAGES shifts.
   always_comb begin
      w_sum = {1'b0, i_beat.a_rem[CHUNK-1:0]} + {1'b0, i_beat.b_rem[CHUNK-1:0]}
            + {{CHUNK{1'b0}}, i_beat.carry};
      w_next        = i_beat;
      w_next.carry  = w_sum[CHUNK];
      w_next.a_rem  = $signed(i_beat.a_rem) >>> CHUNK;
      w_next.b_rem  = $signed(i_beat.b_rem) >>> CHUNK;
      w_next.s_done = (i_beat.s_done >> CHUNK)
                    | (PIPE_MAX_W'(w_sum[CHUNK-1:0]) << (WIDTH - CHUNK));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_beat <= '0;
      end else if (i_adv) begin
         r_beat <= w_next;
      end
   end

   assign o_beat = r_beat;

endmodule

// File: rtl/add_pipe.sv
// Pipelined two's-complement adder/subtractor with valid/ready handshake and full backpressure.
// Flags are derived only from the final stage register.
module add_pipe
   import add_pkg::*;
#(
   parameter int unsigned WIDTH  = DEF_WIDTH,
   parameter int unsigned STAGES = DEF_STAGES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int unsigned CHUNK = WIDTH / STAGES;

   if ((WIDTH % STAGES) != 0 || WIDTH > PIPE_MAX_W) begin : g_bad_cfg
      $error("add_pipe: WIDTH must be a multiple of STAGES and at most PIPE_MAX_W");
   end

   logic             w_adv;
   logic [WIDTH-1:0] w_bx;
   pipe_beat_t       w_in;
   pipe_beat_t       w_beat [STAGES+1];
   pipe_beat_t       w_last;

   assign w_adv    = !out_valid || out_ready;
   assign in_ready = w_adv;

   always_comb begin
      w_bx       = b ^ ((sub == OP_ADD) ? '0 : '1);
      w_in       = '0;
      w_in.valid = in_valid;
      w_in.sub   = sub;
      w_in.carry = cin ^ (sub == OP_SUB);
      w_in.a_rem = PIPE_MAX_W'($signed(a));
      w_in.b_rem = PIPE_MAX_W'($signed(w_bx));
   end

   assign w_beat[0] = w_in;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      add_pipe_stage #(
         .WIDTH (WIDTH),
         .CHUNK (CHUNK)
      ) u_stage (
         .clk    (clk),
         .rst    (rst),
         .i_adv  (w_adv),
         .i_beat (w_beat[k]),
         .o_beat (w_beat[k+1])
      );
   end

   assign w_last = w_beat[STAGES];

   // After the final arithmetic shift every remaining operand bit equals that operand's sign.
   always_comb begin
      out_valid = w_last.valid;
      s         = w_last.s_done[WIDTH-1:0];
      cout      = w_last.carry;
      ovf       = (w_last.a_rem[0] == w_last.b_rem[0]) && (s[WIDTH-1] != w_last.a_rem[0]);
      zero      = w_last.valid && ~|s;
   end

endmodule
